// File: rtl/fp_int_wb_queue.sv
// Result queue between the FP-to-integer stage and the integer writeback port.
// Retiring entries accrue their exception flags into the sticky fflags state.
module fp_int_wb_queue #(
   parameter int DEPTH = 4,
   parameter int TAGW  = 5
) (
   input  logic                     clk,
   input  logic                     rst_l,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [63:0]              in_data,
   input  logic [4:0]               in_exc,
   input  logic [TAGW-1:0]          in_rd,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [63:0]              out_data,
   output logic [TAGW-1:0]          out_rd,
   input  logic                     fflags_we,
   input  logic [4:0]               fflags_wdata,
   output logic [4:0]               fflags,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [63:0]     data;
      logic [4:0]      exc;
      logic [TAGW-1:0] rd;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;
   logic [4:0]      fflags_q;

   logic            enq;
   logic            deq;
   entry_t          head;
   logic [CW-1:0]   count_next;
   logic [4:0]      fflags_next;

   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign enq       = in_valid & in_ready & ~flush;
   assign deq       = out_valid & out_ready;

   assign head      = mem[rd_ptr];
   assign out_data  = head.data;
   assign out_rd    = head.rd;
   assign fflags    = fflags_q;
   assign count     = count_q;

   // NOTE: combinational next-state logic uses blocking assignments with a
   // default first, so no path leaves a variable unassigned (no latch).
   always_comb begin
      count_next = count_q;
      case ({enq, deq})
         2'b10:   count_next = count_q + CW'(1);
         2'b01:   count_next = count_q - CW'(1);
         default: count_next = count_q;
      endcase
      // A flush does not change accrual: a head retiring in the flush cycle
      // still belongs to writeback, and discarded entries never reach here.
      fflags_next = (fflags_we ? fflags_wdata : fflags_q) | (deq ? head.exc : 5'b0);
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         fflags_q <= '0;
      end else begin
         fflags_q <= fflags_next;
         if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
         end else begin
            count_q <= count_next;
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // NOTE: entry storage has no reset; count gates out_valid, so stale
   // contents are never observed and the array maps onto plain registers/RAM.
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= '{data: in_data, exc: in_exc, rd: in_rd};
   end

   a_no_accept_when_full: assert property (
      @(posedge clk) disable iff (!rst_l) (in_valid && !in_ready) |-> !enq);

   a_count_bounded: assert property (
      @(posedge clk) disable iff (!rst_l) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fp_int_wb_queue.sv
// Directed bench for fp_int_wb_queue: a vector table for the basic handshake and
// flag cases, then hand-written wrap, flush and async-reset sequences.
module tb_fp_int_wb_queue;

   logic        clk;
   logic        rst_l;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [4:0]  in_exc;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_rd;
   logic        fflags_we;
   logic [4:0]  fflags_wdata;
   logic [4:0]  fflags;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   fp_int_wb_queue #(.DEPTH(4), .TAGW(5)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_exc       (in_exc),
      .in_rd        (in_rd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_rd       (out_rd),
      .fflags_we    (fflags_we),
      .fflags_wdata (fflags_wdata),
      .fflags       (fflags),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        iv;
      logic [63:0] d;
      logic [4:0]  exc;
      logic [4:0]  rd;
      logic        ordy;
      logic        fl;
      logic        we;
      logic [4:0]  wd;
      logic [2:0]  e_count;
      logic        e_ov;
      logic        e_ir;
      logic [63:0] e_data;
      logic [4:0]  e_rd;
      logic [4:0]  e_ff;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic iv, input logic [63:0] d, input logic [4:0] exc,
                               input logic [4:0] rd, input logic ordy, input logic fl,
                               input logic we, input logic [4:0] wd, input logic [2:0] ec,
                               input logic eov, input logic eir, input logic [63:0] ed,
                               input logic [4:0] erd, input logic [4:0] eff);
      vec_t v;
      v.iv = iv; v.d = d; v.exc = exc; v.rd = rd; v.ordy = ordy; v.fl = fl;
      v.we = we; v.wd = wd; v.e_count = ec; v.e_ov = eov; v.e_ir = eir;
      v.e_data = ed; v.e_rd = erd; v.e_ff = eff;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_data = '0; in_exc = '0; in_rd = '0;
      out_ready = 1'b0; flush = 1'b0; fflags_we = 1'b0; fflags_wdata = '0;
   endtask

   localparam logic [63:0] D0 = 64'hFFFF_FFFF_8000_0000;
   localparam logic [63:0] D1 = 64'h0000_0000_0000_1111;
   localparam logic [63:0] D2 = 64'h0000_0000_0000_2222;
   localparam logic [63:0] D3 = 64'h0000_0000_0000_3333;
   localparam logic [63:0] D4 = 64'h4444_0000_0000_4444;
   localparam logic [63:0] D5 = 64'h5555_5555_5555_5555;
   localparam logic [63:0] D6 = 64'hFFFF_FFFF_FFFF_FFFE;
   localparam logic [63:0] D7 = 64'h0000_0000_0000_0007;
   localparam logic [63:0] D8 = 64'h8000_0000_0000_0008;

   logic [63:0] q_data[$];
   logic [4:0]  q_rd[$];
   logic [4:0]  q_exc[$];
   logic [4:0]  exp_ff;

   initial begin
      idle_inputs();
      rst_l = 1'b0;
      #3;
      check("reset_count", count, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_fflags", fflags, 0);
      #9 rst_l = 1'b1;
      step();

      // Single op, fill/full with ignored 5th, drain in order, CSR collision, enq&deq at count 1.
      vecs.push_back(mk(1, D0, 5'b10000, 7,  1, 0, 0, 5'b0,     1, 1, 1, D0, 7,  5'b00000));
      vecs.push_back(mk(0, 0,  5'b0,     0,  1, 0, 0, 5'b0,     0, 0, 1, 0,  0,  5'b10000));
      vecs.push_back(mk(1, D1, 5'b00001, 1,  0, 0, 0, 5'b0,     1, 1, 1, D1, 1,  5'b10000));
      vecs.push_back(mk(1, D2, 5'b00010, 2,  0, 0, 0, 5'b0,     2, 1, 1, D1, 1,  5'b10000));
      vecs.push_back(mk(1, D3, 5'b00000, 3,  0, 0, 0, 5'b0,     3, 1, 1, D1, 1,  5'b10000));
      vecs.push_back(mk(1, D4, 5'b00000, 4,  0, 0, 0, 5'b0,     4, 1, 0, D1, 1,  5'b10000));
      vecs.push_back(mk(1, D5, 5'b11111, 5,  0, 0, 0, 5'b0,     4, 1, 0, D1, 1,  5'b10000));
      vecs.push_back(mk(0, 0,  5'b0,     0,  1, 0, 0, 5'b0,     3, 1, 1, D2, 2,  5'b10001));
      vecs.push_back(mk(0, 0,  5'b0,     0,  1, 0, 0, 5'b0,     2, 1, 1, D3, 3,  5'b10011));
      vecs.push_back(mk(0, 0,  5'b0,     0,  1, 0, 0, 5'b0,     1, 1, 1, D4, 4,  5'b10011));
      vecs.push_back(mk(0, 0,  5'b0,     0,  1, 0, 0, 5'b0,     0, 0, 1, 0,  0,  5'b10011));
      vecs.push_back(mk(1, D6, 5'b00100, 9,  0, 0, 1, 5'b00001, 1, 1, 1, D6, 9,  5'b00001));
      vecs.push_back(mk(0, 0,  5'b0,     0,  1, 0, 1, 5'b00000, 0, 0, 1, 0,  0,  5'b00100));
      vecs.push_back(mk(1, D7, 5'b00000, 10, 0, 0, 0, 5'b0,     1, 1, 1, D7, 10, 5'b00100));
      vecs.push_back(mk(1, D8, 5'b00000, 11, 1, 0, 0, 5'b0,     1, 1, 1, D8, 11, 5'b00100));
      vecs.push_back(mk(0, 0,  5'b0,     0,  1, 0, 0, 5'b0,     0, 0, 1, 0,  0,  5'b00100));

      for (int i = 0; i < vecs.size(); i++) begin
         in_valid = vecs[i].iv; in_data = vecs[i].d; in_exc = vecs[i].exc; in_rd = vecs[i].rd;
         out_ready = vecs[i].ordy; flush = vecs[i].fl;
         fflags_we = vecs[i].we; fflags_wdata = vecs[i].wd;
         step();
         check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
         check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
         check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
         check($sformatf("vec%0d_fflags", i), fflags, vecs[i].e_ff);
         if (vecs[i].e_ov) begin
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
            check($sformatf("vec%0d_out_rd", i), out_rd, vecs[i].e_rd);
         end
      end
      idle_inputs();

      // Wrap: 10 back-to-back ops, out_ready toggling, checked against a queue model.
      begin
         int sent = 0;
         int got = 0;
         int cyc = 0;
         int sz;
         exp_ff = 5'b00100;
         while (got < 10 && cyc < 60) begin
            in_valid  = (sent < 10);
            in_data   = 64'hA000_0000_0000_0000 + 64'(sent);
            in_rd     = 5'(sent + 12);
            in_exc    = (sent == 5) ? 5'b01000 : 5'b00000;
            out_ready = (cyc % 2 == 0);
            sz = q_data.size();
            check("wrap_count", count, sz);
            check("wrap_count_le_depth", (count <= 3'd4), 1);
            check("wrap_out_valid", out_valid, (sz != 0));
            if (out_ready && sz != 0) begin
               check("wrap_out_data", out_data, q_data[0]);
               check("wrap_out_rd", out_rd, q_rd[0]);
               exp_ff = exp_ff | q_exc[0];
               void'(q_data.pop_front());
               void'(q_rd.pop_front());
               void'(q_exc.pop_front());
               got++;
            end
            if (in_valid && sz != 4) begin
               q_data.push_back(in_data);
               q_rd.push_back(in_rd);
               q_exc.push_back(in_exc);
               sent++;
            end
            step();
            cyc++;
         end
         idle_inputs();
         check("wrap_delivered", got, 10);
         check("wrap_end_count", count, 0);
         check("wrap_fflags", fflags, exp_ff);
      end

      // Flush with 3 NV entries buffered and an incoming result; nothing accrues.
      fflags_we = 1'b1; fflags_wdata = 5'b00000;
      step();
      idle_inputs();
      check("flush_pre_fflags", fflags, 0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 64'(i + 100); in_exc = 5'b10000; in_rd = 5'(i);
         step();
      end
      check("flush_pre_count", count, 3);
      in_valid = 1'b1; in_data = 64'hDEAD; in_exc = 5'b10000; in_rd = 5'd30;
      flush = 1'b1;
      step();
      idle_inputs();
      check("flush_count", count, 0);
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      check("flush_fflags", fflags, 0);
      step();
      check("flush_dropped_input", count, 0);

      // A deq in the flush cycle still retires and accrues only its own flags.
      in_valid = 1'b1; in_data = 64'h11; in_exc = 5'b00010; in_rd = 5'd1;
      step();
      in_data = 64'h22; in_exc = 5'b01000; in_rd = 5'd2;
      step();
      idle_inputs();
      check("flushdeq_pre_count", count, 2);
      flush = 1'b1; out_ready = 1'b1;
      step();
      idle_inputs();
      check("flushdeq_fflags", fflags, 5'b00010);
      check("flushdeq_count", count, 0);

      // Async reset mid-burst with count=2 and fflags=00011.
      fflags_we = 1'b1; fflags_wdata = 5'b00011;
      in_valid = 1'b1; in_data = 64'h33; in_exc = 5'b0; in_rd = 5'd3;
      step();
      fflags_we = 1'b0;
      in_data = 64'h44; in_rd = 5'd4;
      step();
      idle_inputs();
      check("rst_pre_count", count, 2);
      check("rst_pre_fflags", fflags, 5'b00011);
      #2 rst_l = 1'b0;
      #1;
      check("rst_async_count", count, 0);
      check("rst_async_out_valid", out_valid, 0);
      check("rst_async_fflags", fflags, 0);
      check("rst_async_in_ready", in_ready, 1);
      #3 rst_l = 1'b1;
      step();
      check("rst_post_count", count, 0);
      check("rst_post_out_valid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
